stopwatch_counter: RTL
======================

# stopwatch_counter

Minutes:seconds BCD timekeeping core for the stopwatch; it sits directly downstream of the clock divider. The core consumes the divider's single-cycle `one_hz_clk` and `two_hz_clk` enable pulses. It counts MM:SS in run mode, holds the count when paused, and lets the user step the minutes or seconds field at 2 Hz in adjust mode. Its BCD digit outputs feed the seven-segment display scanner.

## Interface
Parameters:
- `MAX_MINUTES`, default 59: highest minutes value before wrap; legal range 1–99.

Ports:
- `clk`  in  1  100 MHz system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `one_hz_tick`  in  1  one-cycle enable pulse, 1 Hz, from the clock divider.
- `two_hz_tick`  in  1  one-cycle enable pulse, 2 Hz, from the clock divider.
- `pause_pulse`  in  1  debounced one-cycle button press; toggles run/pause.
- `adj`  in  1  level; 1 = adjust mode.
- `sel`  in  1  level; adjust target: 0 = minutes, 1 = seconds.
- `min_tens`  out  4  BCD minutes tens digit.
- `min_ones`  out  4  BCD minutes ones digit.
- `sec_tens`  out  4  BCD seconds tens digit (0–5).
- `sec_ones`  out  4  BCD seconds ones digit.
- `running`  out  1  1 when the FSM is in RUN.
- `rollover`  out  1  one-cycle pulse on a count-mode wrap from MAX_MINUTES:59 to 00:00.

## Operation
- FSM states are RUN and PAUSED. `pause_pulse` toggles between them in any mode, adjust included.
- Count mode (`adj`=0, RUN), on each `one_hz_tick`:
  - seconds +1;
  - at seconds 59: seconds → 00, minutes +1;
  - at MAX_MINUTES:59: time → 00:00 and `rollover` pulses.
- Count mode, PAUSED: `one_hz_tick` is ignored.
- Adjust mode (`adj`=1):
  - `one_hz_tick` is ignored regardless of FSM state.
  - On each `two_hz_tick`, the field chosen by `sel` increments by 1.
  - Seconds wrap 59 → 00; minutes wrap MAX_MINUTES → 00.
  - There is no carry between fields and no `rollover` pulse.
- BCD rules:
  - each ones digit wraps 9 → 0 and carries into its tens digit;
  - the field-limit check uses the full two-digit value;
  - no digit ever takes a value above 9.
- Simultaneous events:
  - `one_hz_tick` and `two_hz_tick` coincide once per second. Only the tick selected by `adj` acts, so there is never a double increment.
  - When `pause_pulse` and `one_hz_tick` arrive in the same cycle, the tick is evaluated against the pre-toggle state. RUN therefore counts that tick and then pauses.
  - `adj` or `sel` changing in the same cycle as a tick: the new value governs that tick.
- `rst` overrides all inputs. It drives 00:00, RUN, and `rollover`=0.

## Timing
- All outputs are registered. Digits update on the clock edge that samples the tick, so they are visible 1 cycle after the tick is high.
- `rollover` is high for exactly 1 cycle, aligned with the 00:00 digit update.
- `running` updates 1 cycle after `pause_pulse`.
- Reset values: every digit 0, `running`=1, `rollover`=0. The reset takes effect on the first edge with `rst`=1 and holds while `rst` stays high.
- Reset mid-operation discards the count. The first tick after `rst` falls counts from 00:00.
- Ticks are edge-independent enables. A tick held high for N cycles produces N increments; the upstream divider guarantees N=1.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the FSM state enum (RUN, PAUSED);
  - the BCD digit width constant (4);
  - the seconds limit constant (59).
- Sub-module `bcd2_counter` is a two-digit BCD counter. Ports:
  - `clk`, `rst`;
  - `inc`;
  - `limit` (8-bit BCD);
  - `carry_out`, asserted when an increment wraps limit → 00;
  - `tens`, `ones`.
- It is instantiated twice:
  - seconds: `limit`=59, `inc` = count tick or adjust tick;
  - minutes: `limit`=MAX_MINUTES, `inc` = seconds `carry_out` in count mode or adjust tick.
- The top level contains the FSM, tick qualification, and `rollover` generation (minutes `carry_out` in count mode).

## Test plan
- Reset, then 61 `one_hz_tick` pulses in RUN → display 01:01; `running`=1.
- Preload 58:59 with MAX_MINUTES=59, then one tick → 59:00. Preload 59:59, then one tick → 00:00 with `rollover` high for exactly 1 cycle.
- `pause_pulse` then 5 ticks → count unchanged and `running`=0. A second `pause_pulse` then 1 tick → count +1s.
- `adj`=1, `sel`=1 at 00:58, then 3 `two_hz_tick` → 00:01, minutes unchanged, no `rollover`. Same stimulus with `sel`=0 at 58:00 → 01:00 (MAX_MINUTES=59).
- `one_hz_tick` and `two_hz_tick` in the same cycle: `adj`=0 gives +1 s; `adj`=1, `sel`=1 gives +1 s. Never +2.
- `rst` asserted mid-count at 12:34 → 00:00 and `running`=1 on the next edge. `pause_pulse` coincident with a tick in RUN → count +1 and `running`=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch timekeeping core.
package stopwatch_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  localparam int unsigned DIGIT_W   = 4;
  localparam logic [7:0]  SEC_LIMIT = 8'h59;

  // Binary 0..99 to packed two-digit BCD.
  function automatic logic [7:0] to_bcd2(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps from a BCD limit back to 00 and flags the wrap.
module bcd2_counter
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic [7:0]         limit,
  output logic               carry_out,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones
);

  logic [DIGIT_W-1:0] r_tens;
  logic [DIGIT_W-1:0] r_ones;
  logic               w_at_limit;

  assign w_at_limit = ({r_tens, r_ones} == limit);
  // Combinational so the next field can step on the same edge as this wrap.
  assign carry_out  = inc && w_at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (inc) begin
      if (w_at_limit) begin
        r_tens <= '0;
        r_ones <= '0;
      end else if (r_ones == 4'd9) begin
        r_ones <= '0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign tens = r_tens;
  assign ones = r_ones;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch core: run/pause FSM, tick qualification, field counters.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MINUTES = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               one_hz_tick,
  input  logic               two_hz_tick,
  input  logic               pause_pulse,
  input  logic               adj,
  input  logic               sel,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               rollover
);

  localparam logic [7:0] MIN_LIMIT = to_bcd2(MAX_MINUTES);

  state_t r_state;
  state_t w_state_next;
  logic   r_rollover;

  logic w_count_tick;
  logic w_adj_tick;
  logic w_sec_inc;
  logic w_min_inc;
  logic w_sec_carry;
  logic w_min_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (pause_pulse) begin
      w_state_next = (r_state == RUN) ? PAUSED : RUN;
    end
  end

  // Ticks qualify against the current (pre-toggle) state; adj picks which tick acts.
  assign w_count_tick = !adj && (r_state == RUN) && one_hz_tick;
  assign w_adj_tick   = adj && two_hz_tick;
  assign w_sec_inc    = w_count_tick || (w_adj_tick && sel);
  assign w_min_inc    = (w_count_tick && w_sec_carry) || (w_adj_tick && !sel);

  bcd2_counter u_sec (
    .clk       (clk),
    .rst       (rst),
    .inc       (w_sec_inc),
    .limit     (SEC_LIMIT),
    .carry_out (w_sec_carry),
    .tens      (sec_tens),
    .ones      (sec_ones)
  );

  bcd2_counter u_min (
    .clk       (clk),
    .rst       (rst),
    .inc       (w_min_inc),
    .limit     (MIN_LIMIT),
    .carry_out (w_min_carry),
    .tens      (min_tens),
    .ones      (min_ones)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= w_count_tick && w_min_carry;
    end
  end

  assign running  = (r_state == RUN);
  assign rollover = r_rollover;

endmodule
